dice_roller: RTL

//  Dice roll controller downstream of the prescaler. Uses the prescaler's slow square wave as a tick

---
 rtl/dice_pkg.sv | 47 ++++
 rtl/dice_roller_sync_edge.sv | 30 +++
 rtl/dice_roller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll controller: FSM states,
// pip masks for each face, LFSR tap mask and small face helpers.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROLL  = 2'd1,
        DECEL = 2'd2,
        SHOW  = 2'd3
    } state_t;

    // Pip order is {TL,TR,ML,C,MR,BL,BR}, active-high.
    localparam logic [6:0] PIP_1 = 7'b0001000;
    localparam logic [6:0] PIP_2 = 7'b1000001;
    localparam logic [6:0] PIP_3 = 7'b1001001;
    localparam logic [6:0] PIP_4 = 7'b1100011;
    localparam logic [6:0] PIP_5 = 7'b1101011;
    localparam logic [6:0] PIP_6 = 7'b1110111;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [6:0] pip_decode(input logic [2:0] f);
        logic [6:0] p;
        case (f)
            3'd1:    p = PIP_1;
            3'd2:    p = PIP_2;
            3'd3:    p = PIP_3;
            3'd4:    p = PIP_4;
            3'd5:    p = PIP_5;
            3'd6:    p = PIP_6;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // Next face in the 1..6 cycle.
    function automatic logic [2:0] face_advance(input logic [2:0] f);
        return (f == 3'd6) ? 3'd1 : f + 3'd1;
    endfunction

    // Map an LFSR value onto a face 1..6.
    function automatic logic [2:0] lfsr_face(input logic [15:0] v);
        return 3'(v % 16'd6) + 3'd1;
    endfunction

endpackage

// File: rtl/dice_roller_sync_edge.sv
// Three-flop chain for an asynchronous input: two flops resolve
// metastability, the third delays the synchronised level so a one-cycle
// pulse marks each rising edge.
module sync_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    // Synchronise the input and keep one cycle of history for edge detection.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign rise = s2_reg & ~s3_reg;

endmodule

// File: rtl/dice_roller.sv
// Dice roll controller. The prescaler's slow square wave is only ever used
// as a synchronised tick enable. The roll button is debounced in tick units
// and drives a ROLL/DECEL/SHOW state machine animating a face 1..6.
module dice_roller
    import dice_pkg::*;
#(
    parameter int          DEBOUNCE_TICKS = 4,
    parameter int          DECEL_STEPS    = 6,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       btn_roll,
    output logic [2:0] face,
    output logic [6:0] pips,
    output logic       rolling,
    output logic       done
);

    localparam int CNT_W  = $clog2(DEBOUNCE_TICKS) + 1;
    localparam int STEP_W = $clog2(DECEL_STEPS) + 1;

    logic              tick_en;
    logic              b1_reg;
    logic              b_s_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              btn_db_reg;
    logic              btn_db_prev_reg;
    logic              btn_press;
    logic              btn_release;
    logic [15:0]       lfsr_reg;
    state_t            state_reg;
    state_t            state_next;
    logic [2:0]        face_reg;
    logic [2:0]        face_next;
    logic [STEP_W-1:0] step_reg;
    logic [STEP_W-1:0] step_next;
    logic [STEP_W-1:0] gap_reg;
    logic [STEP_W-1:0] gap_next;
    logic              done_reg;
    logic              done_next;

    sync_edge u_tick_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .din    (tick_in),
        .rise   (tick_en)
    );

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            b1_reg  <= 1'b0;
            b_s_reg <= 1'b0;
        end else begin
            b1_reg  <= btn_roll;
            b_s_reg <= b1_reg;
        end
    end

    // Debounce: btn_db follows b_s only after DEBOUNCE_TICKS consecutive differing tick samples.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt_reg    <= '0;
            btn_db_reg <= 1'b0;
        end else if (tick_en) begin
            if (b_s_reg == btn_db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                btn_db_reg <= b_s_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Delayed copy of the debounced button for press/release pulses.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            btn_db_prev_reg <= 1'b0;
        end else begin
            btn_db_prev_reg <= btn_db_reg;
        end
    end

    assign btn_press   =  btn_db_reg & ~btn_db_prev_reg;
    assign btn_release = ~btn_db_reg &  btn_db_prev_reg;

    // Free-running Fibonacci LFSR; its value at release time picks the landing face.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            face_reg  <= 3'd1;
            step_reg  <= '0;
            gap_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            face_reg  <= face_next;
            step_reg  <= step_next;
            gap_reg   <= gap_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic. Deceleration step k waits k ticks before advancing,
    // so the gaps grow and the die visibly slows before landing.
    always_comb begin
        state_next = state_reg;
        face_next  = face_reg;
        step_next  = step_reg;
        gap_next   = gap_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                face_next = 3'd1;
                if (btn_press) begin
                    state_next = ROLL;
                end
            end
            ROLL: begin
                // Release wins over a coincident tick so the loaded face is not advanced.
                if (btn_release) begin
                    state_next = DECEL;
                    face_next  = lfsr_face(lfsr_reg);
                    step_next  = '0;
                    gap_next   = '0;
                end else if (tick_en) begin
                    face_next = face_advance(face_reg);
                end
            end
            DECEL: begin
                if (tick_en) begin
                    if (gap_reg == step_reg) begin
                        face_next = face_advance(face_reg);
                        gap_next  = '0;
                        if (step_reg == STEP_W'(DECEL_STEPS - 1)) begin
                            state_next = SHOW;
                            step_next  = '0;
                            done_next  = 1'b1;
                        end else begin
                            step_next = step_reg + STEP_W'(1);
                        end
                    end else begin
                        gap_next = gap_reg + STEP_W'(1);
                    end
                end
            end
            SHOW: begin
                if (btn_press) begin
                    state_next = ROLL;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign face    = face_reg;
    assign pips    = pip_decode(face_reg);
    assign rolling = (state_reg == ROLL) || (state_reg == DECEL);
    assign done    = done_reg;

endmodule
